// File: rtl/timer_ui_ctrl.sv
// Button-driven front end for the count-down timer: edits the HH:MM:SS preset in
// BCD, sequences set/play/stop command pulses and drives a time-limited alarm.
module timer_ui_ctrl #(
  parameter int BLINK_HALF   = 25_000_000,
  parameter int RING_TIMEOUT = 1_500_000_000
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  input  logic       counting,
  input  logic       ring,
  output logic       set,
  output logic       play,
  output logic       stop,
  output logic [7:0] hour_bcd,
  output logic [7:0] minute_bcd,
  output logic [7:0] second_bcd,
  output logic [1:0] edit_field,
  output logic       blink,
  output logic       alarm_out,
  output logic [3:0] state_dbg
);

  // Handshake: every button input and every command output is a one-cycle pulse
  // with no back-pressure; a pulse is consumed in the cycle it is high or lost.

  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [30:0]   RING_LAST  = 31'(RING_TIMEOUT - 1);

  // Debug encoding on state_dbg[2:0]: 0 IDLE, 1 EDIT, 2 LOAD, 3 RUN, 4 PAUSE, 5 ALARM.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EDIT  = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_PAUSE = 3'd4,
    S_ALARM = 3'd5
  } state_t;

  state_t state, state_d;

  logic          set_d, play_d, stop_d;
  logic [7:0]    hour_d, minute_d, second_d;
  logic [1:0]    field_d;
  logic          blink_d, blink_clr;
  logic          alarm_d;
  logic [BW-1:0] blink_cnt, blink_cnt_d;
  logic [30:0]   ring_cnt, ring_cnt_d;
  logic          counting_q;
  logic          preset_zero;
  logic          any_btn;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v == max)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v == 8'h00)
      r = max;
    else if (v[3:0] == 4'd0)
      r = {v[7:4] - 4'd1, 4'd9};
    else
      r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  assign preset_zero = (hour_bcd == 8'h00) && (minute_bcd == 8'h00) && (second_bcd == 8'h00);
  assign any_btn     = btn_mode | btn_up | btn_down | btn_start;
  assign state_dbg   = {counting_q, state};

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      set        <= 1'b0;
      play       <= 1'b0;
      stop       <= 1'b0;
      hour_bcd   <= 8'h00;
      minute_bcd <= 8'h00;
      second_bcd <= 8'h00;
      edit_field <= 2'd0;
      blink      <= 1'b0;
      alarm_out  <= 1'b0;
      blink_cnt  <= '0;
      ring_cnt   <= '0;
      counting_q <= 1'b0;
    end else begin
      state      <= state_d;
      set        <= set_d;
      play       <= play_d;
      stop       <= stop_d;
      hour_bcd   <= hour_d;
      minute_bcd <= minute_d;
      second_bcd <= second_d;
      edit_field <= field_d;
      blink      <= blink_d;
      alarm_out  <= alarm_d;
      blink_cnt  <= blink_cnt_d;
      ring_cnt   <= ring_cnt_d;
      counting_q <= counting;
    end
  end

  always_comb begin
    state_d   = state;
    set_d     = 1'b0;
    play_d    = 1'b0;
    stop_d    = 1'b0;
    hour_d    = hour_bcd;
    minute_d  = minute_bcd;
    second_d  = second_bcd;
    field_d   = edit_field;
    blink_clr = 1'b0;

    // Priority start > mode > up > down: each branch chain tests them in that order.
    case (state)
      S_IDLE: begin
        if (btn_start) begin
          if (!preset_zero) begin
            play_d  = 1'b1;
            state_d = S_RUN;
          end
        end else if (btn_mode) begin
          state_d   = S_EDIT;
          field_d   = 2'd1;
          blink_clr = 1'b1;
        end
      end

      S_EDIT: begin
        if (btn_start) begin
          set_d   = 1'b1;
          field_d = 2'd0;
          state_d = S_LOAD;
        end else if (btn_mode) begin
          if (edit_field == 2'd3) begin
            set_d   = 1'b1;
            field_d = 2'd0;
            state_d = S_IDLE;
          end else begin
            field_d   = edit_field + 2'd1;
            blink_clr = 1'b1;
          end
        end else if (btn_up || btn_down) begin
          blink_clr = 1'b1;
          case (edit_field)
            2'd1:    hour_d   = btn_up ? bcd_inc(hour_bcd, 8'h23)   : bcd_dec(hour_bcd, 8'h23);
            2'd2:    minute_d = btn_up ? bcd_inc(minute_bcd, 8'h59) : bcd_dec(minute_bcd, 8'h59);
            2'd3:    second_d = btn_up ? bcd_inc(second_bcd, 8'h59) : bcd_dec(second_bcd, 8'h59);
            default: ;
          endcase
        end
      end

      S_LOAD: begin
        if (!preset_zero) begin
          play_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        if (ring) begin
          state_d = S_ALARM;
        end else if (btn_start) begin
          stop_d  = 1'b1;
          state_d = S_PAUSE;
        end
      end

      S_PAUSE: begin
        if (btn_start) begin
          play_d  = 1'b1;
          state_d = S_RUN;
        end else if (btn_mode) begin
          set_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_ALARM: begin
        // The set pulse also clears the timer's ring level.
        if (any_btn || (ring_cnt == RING_LAST)) begin
          set_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    alarm_d = (state_d == S_ALARM);

    if (state == S_ALARM && state_d == S_ALARM)
      ring_cnt_d = ring_cnt + 31'd1;
    else
      ring_cnt_d = '0;

    // Blink restarts in the visible phase whenever the user touches the edit.
    if (state_d != S_EDIT) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (blink_clr) begin
      blink_cnt_d = '0;
      blink_d     = 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_d     = ~blink;
    end else begin
      blink_cnt_d = blink_cnt + {{(BW-1){1'b0}}, 1'b1};
      blink_d     = blink;
    end
  end

endmodule

// File: tb/tb_timer_ui_ctrl.sv
// Self-checking bench for timer_ui_ctrl: directed scenarios plus random button
// traffic, compared every cycle against an integer-arithmetic behavioural model.
module tb_timer_ui_ctrl;

  localparam int BLINK_HALF   = 4;
  localparam int RING_TIMEOUT = 100;

  localparam logic [3:0] B_START = 4'b1000;
  localparam logic [3:0] B_MODE  = 4'b0100;
  localparam logic [3:0] B_UP    = 4'b0010;
  localparam logic [3:0] B_DOWN  = 4'b0001;

  localparam int P_IDLE  = 0;
  localparam int P_EDIT  = 1;
  localparam int P_LOAD  = 2;
  localparam int P_RUN   = 3;
  localparam int P_PAUSE = 4;
  localparam int P_ALARM = 5;

  logic       clk_50M = 1'b0;
  logic       rst_n;
  logic       btn_mode, btn_up, btn_down, btn_start;
  logic       counting, ring;
  logic       set, play, stop;
  logic [7:0] hour_bcd, minute_bcd, second_bcd;
  logic [1:0] edit_field;
  logic       blink, alarm_out;
  logic [3:0] state_dbg;

  int n_checks = 0;
  int n_err    = 0;

  // ---------------- clock / reset ----------------
  always #5 clk_50M = ~clk_50M;

  timer_ui_ctrl #(
    .BLINK_HALF  (BLINK_HALF),
    .RING_TIMEOUT(RING_TIMEOUT)
  ) dut (
    .clk_50M   (clk_50M),
    .rst_n     (rst_n),
    .btn_mode  (btn_mode),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_start (btn_start),
    .counting  (counting),
    .ring      (ring),
    .set       (set),
    .play      (play),
    .stop      (stop),
    .hour_bcd  (hour_bcd),
    .minute_bcd(minute_bcd),
    .second_bcd(second_bcd),
    .edit_field(edit_field),
    .blink     (blink),
    .alarm_out (alarm_out),
    .state_dbg (state_dbg)
  );

  // ---------------- behavioural model ----------------
  int m_phase, m_h, m_m, m_s, m_field, m_edit_age, m_alarm_age;
  int step, lim;
  bit m_set, m_play, m_stop;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  always @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = P_IDLE; m_h = 0; m_m = 0; m_s = 0; m_field = 0;
      m_edit_age = 0; m_alarm_age = 0;
      m_set = 0; m_play = 0; m_stop = 0;
    end else begin
      m_set = 0; m_play = 0; m_stop = 0;
      case (m_phase)
        P_IDLE: begin
          if (btn_start) begin
            if (m_h + m_m + m_s != 0) begin m_play = 1; m_phase = P_RUN; end
          end else if (btn_mode) begin
            m_phase = P_EDIT; m_field = 1; m_edit_age = 0;
          end
        end
        P_EDIT: begin
          if (btn_start) begin
            m_set = 1; m_field = 0; m_phase = P_LOAD;
          end else if (btn_mode) begin
            if (m_field == 3) begin m_set = 1; m_field = 0; m_phase = P_IDLE; end
            else begin m_field = m_field + 1; m_edit_age = 0; end
          end else if (btn_up || btn_down) begin
            step = btn_up ? 1 : -1;
            lim  = (m_field == 1) ? 24 : 60;
            if (m_field == 1) m_h = (m_h + step + lim) % lim;
            if (m_field == 2) m_m = (m_m + step + lim) % lim;
            if (m_field == 3) m_s = (m_s + step + lim) % lim;
            m_edit_age = 0;
          end else begin
            m_edit_age = m_edit_age + 1;
          end
        end
        P_LOAD: begin
          if (m_h + m_m + m_s != 0) begin m_play = 1; m_phase = P_RUN; end
          else m_phase = P_IDLE;
        end
        P_RUN: begin
          if (ring) begin m_phase = P_ALARM; m_alarm_age = 0; end
          else if (btn_start) begin m_stop = 1; m_phase = P_PAUSE; end
        end
        P_PAUSE: begin
          if (btn_start) begin m_play = 1; m_phase = P_RUN; end
          else if (btn_mode) begin m_set = 1; m_phase = P_IDLE; end
        end
        P_ALARM: begin
          if (btn_start || btn_mode || btn_up || btn_down || m_alarm_age == RING_TIMEOUT - 1) begin
            m_set = 1; m_phase = P_IDLE;
          end else begin
            m_alarm_age = m_alarm_age + 1;
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_50M) begin
    #1;
    if (rst_n) begin
      chk("set", 32'(set), 32'(m_set));
      chk("play", 32'(play), 32'(m_play));
      chk("stop", 32'(stop), 32'(m_stop));
      chk("hour", 32'(hour_bcd), 32'(to_bcd(m_h)));
      chk("minute", 32'(minute_bcd), 32'(to_bcd(m_m)));
      chk("second", 32'(second_bcd), 32'(to_bcd(m_s)));
      chk("edit_field", 32'(edit_field), 32'(m_field));
      chk("blink", 32'(blink),
          32'((m_phase == P_EDIT) && ((m_edit_age / BLINK_HALF) % 2 == 0)));
      chk("alarm_out", 32'(alarm_out), 32'(m_phase == P_ALARM));
      chk("state", 32'(state_dbg[2:0]), 32'(m_phase));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] b);
    {btn_start, btn_mode, btn_up, btn_down} = b;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  task automatic pulse(input logic [3:0] b);
    drive(b);
    @(negedge clk_50M);
    drive(4'b0000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  int n_alarm;
  logic [3:0] rb;

  initial begin
    rst_n = 1'b0; counting = 1'b0; ring = 1'b0;
    drive(4'b0000);
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // Reset values and zero-preset start guard
    chk("rst_state", 32'(state_dbg[2:0]), 32'd0);
    chk("rst_hour", 32'(hour_bcd), 32'h00);
    chk("rst_blink", 32'(blink), 32'd0);
    pulse(B_START);
    chk("zero_guard_play", 32'(play), 32'd0);
    chk("zero_guard_state", 32'(state_dbg[2:0]), 32'd0);

    // Edit wrap and blink phase
    pulse(B_MODE);
    chk("edit_field_1", 32'(edit_field), 32'd1);
    chk("blink_entry", 32'(blink), 32'd1);
    tick(3);
    chk("blink_hold", 32'(blink), 32'd1);
    tick(1);
    chk("blink_toggle", 32'(blink), 32'd0);
    pulse(B_DOWN);
    chk("hour_wrap", 32'(hour_bcd), 32'h23);
    chk("blink_restart", 32'(blink), 32'd1);
    pulse(B_MODE);
    repeat (60) pulse(B_UP);
    chk("minute_wrap", 32'(minute_bcd), 32'h00);
    pulse(B_MODE);
    pulse(B_DOWN);
    chk("second_wrap", 32'(second_bcd), 32'h59);
    pulse(B_MODE);
    chk("mode_exit_set", 32'(set), 32'd1);
    chk("mode_exit_field", 32'(edit_field), 32'd0);
    tick(1);
    chk("mode_exit_set_width", 32'(set), 32'd0);

    // Start from EDIT: set at T+1, play at T+2
    pulse(B_MODE); pulse(B_MODE); pulse(B_MODE);
    repeat (6) pulse(B_UP);
    chk("second_05", 32'(second_bcd), 32'h05);
    pulse(B_START);
    chk("load_set", 32'(set), 32'd1);
    chk("load_no_play", 32'(play), 32'd0);
    tick(1);
    chk("load_set_width", 32'(set), 32'd0);
    chk("load_play", 32'(play), 32'd1);
    chk("load_run", 32'(state_dbg[2:0]), 32'd3);
    tick(1);
    chk("load_play_width", 32'(play), 32'd0);

    // Pause / resume / abort
    pulse(B_START);
    chk("pause_stop", 32'(stop), 32'd1);
    pulse(B_START);
    chk("resume_play", 32'(play), 32'd1);
    chk("resume_no_stop", 32'(stop), 32'd0);
    pulse(B_START);
    chk("pause2_stop", 32'(stop), 32'd1);
    pulse(B_MODE);
    chk("abort_set", 32'(set), 32'd1);
    chk("abort_state", 32'(state_dbg[2:0]), 32'd0);
    chk("abort_preset", 32'({hour_bcd, minute_bcd, second_bcd}), 32'h230005);

    // Alarm timeout
    pulse(B_START);
    ring = 1'b1;
    tick(1);
    chk("alarm_rise", 32'(alarm_out), 32'd1);
    n_alarm = 0;
    while (alarm_out && n_alarm < 300) begin
      n_alarm++;
      tick(1);
    end
    chk("alarm_len", 32'(n_alarm), 32'd100);
    chk("alarm_timeout_set", 32'(set), 32'd1);
    tick(2);
    chk("stale_ring_ignored", 32'(state_dbg[2:0]), 32'd0);
    ring = 1'b0;

    // Alarm acknowledged by a button at cycle 10
    pulse(B_START);
    ring = 1'b1;
    tick(1);
    chk("ack_alarm_rise", 32'(alarm_out), 32'd1);
    tick(9);
    pulse(B_UP);
    chk("ack_alarm_low", 32'(alarm_out), 32'd0);
    chk("ack_set", 32'(set), 32'd1);
    tick(1);
    ring = 1'b0;

    // Priority: start beats mode in IDLE
    pulse(B_START | B_MODE);
    chk("prio_play", 32'(play), 32'd1);
    chk("prio_state", 32'(state_dbg[2:0]), 32'd3);
    chk("prio_field", 32'(edit_field), 32'd0);
    pulse(B_START);
    pulse(B_MODE);

    // Asynchronous reset during alarm
    pulse(B_START);
    ring = 1'b1;
    tick(5);
    chk("pre_reset_alarm", 32'(alarm_out), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_alarm_drop", 32'(alarm_out), 32'd0);
    chk("reset_no_set", 32'(set), 32'd0);
    chk("reset_hour", 32'(hour_bcd), 32'h00);
    ring = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("reset_exit_no_set", 32'(set), 32'd0);
    chk("reset_exit_no_stop", 32'(stop), 32'd0);

    // Random traffic
    repeat (4000) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 4) == 0) rb = 4'($urandom_range(1, 15));
        else rb = 4'b0001 << $urandom_range(0, 3);
      end else begin
        rb = 4'b0000;
      end
      drive(rb);
      ring     = ($urandom_range(0, 19) == 0);
      counting = 1'($urandom_range(0, 1));
      @(negedge clk_50M);
    end
    drive(4'b0000);
    ring = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/timer_ui_ctrl.md
# timer_ui_ctrl

Button-driven controller that sequences the count-down timer: edits the HH:MM:SS preset in BCD, and issues single-cycle `set`/`play`/`stop` pulses to the timer. It takes the timer's `counting` and `ring` status back and drives a time-limited alarm output. Sits between the debounced-button block and the count-down timer, in the `clk_50M` domain.

## Interface
- `BLINK_HALF`, 25_000_000: cycles per half-period of the edit-field blink (0.5 s at 50 MHz).
- `RING_TIMEOUT`, 1_500_000_000: cycles `alarm_out` stays high without acknowledgement (30 s); counter is 31 bits.
- `clk_50M` in 1: system clock, 50 MHz.
- `rst_n` in 1: reset; asynchronous, active-low.
- `btn_mode`, `btn_up`, `btn_down`, `btn_start` in 1 each: debounced single-cycle button pulses.
- `counting` in 1: timer running status. Informational only; not used for transitions.
- `ring` in 1: timer expiry level. Held high by the timer until it receives `set`.
- `set`, `play`, `stop` out 1 each: single-cycle command pulses to the timer.
- `hour_bcd`, `minute_bcd`, `second_bcd` out 8 each: preset value in BCD; wired to the timer load inputs.
- `edit_field` out 2: field being edited. 0 = none, 1 = hour, 2 = minute, 3 = second.
- `blink` out 1: display blanking phase for the edited field.
- `alarm_out` out 1: buzzer enable.

## Operation
- FSM states: IDLE, EDIT, LOAD, RUN, PAUSE, ALARM.
- Button priority within one cycle: start > mode > up > down. Only the highest-priority pulse is acted on; the rest are dropped.
- **IDLE**
  - `btn_mode` → EDIT, `edit_field`=1.
  - `btn_start` with preset ≠ 00:00:00 → `play`, go to RUN.
  - `btn_start` with preset = 00:00:00 is ignored.
- **EDIT**
  - `btn_up` / `btn_down` increment/decrement the selected field in BCD, with wrap: hour 00↔23, minute and second 00↔59.
  - `btn_mode` advances the field 1→2→3. From field 3 it issues `set`, sets `edit_field`=0 and goes to IDLE.
  - `btn_start` issues `set` and goes to LOAD (`edit_field`=0).
- **LOAD** (one cycle)
  - Issues `play` if preset ≠ 0, then goes to RUN.
  - If preset = 0, issues no `play` and goes to IDLE.
- **RUN**
  - `ring`=1 → ALARM. This takes priority over buttons.
  - `btn_start` → `stop`, go to PAUSE.
  - `btn_mode`, `btn_up`, `btn_down` are ignored.
- **PAUSE**
  - `btn_start` → `play`, go to RUN.
  - `btn_mode` → `set` (reloads the preset, clears the remaining count), go to IDLE.
- **ALARM**
  - `alarm_out`=1; the timeout counter increments every cycle.
  - Any button pulse, or the counter reaching `RING_TIMEOUT`−1, issues `set` (clears the timer's `ring`) and goes to IDLE.
- The preset registers are held through RUN, PAUSE and ALARM, so a `set` always reloads the last edited value.
- **Blink**
  - The divider counts only in EDIT. It is cleared on entry to EDIT, on a field change, and on any up/down edit; `blink` is forced to 1 at each clear.
  - `blink` toggles every `BLINK_HALF` cycles.
  - `blink`=0 outside EDIT.

## Timing
- Reset values: state IDLE; all presets 8'h00; `edit_field` 0; `blink` 0; `set`/`play`/`stop` 0; `alarm_out` 0; counters 0.
- All outputs are registered.
- A command pulse is high for exactly one cycle, in the cycle after the button pulse.
- Preset and `edit_field` changes are visible one cycle after the button pulse.
- EDIT + `btn_start` gives:
  - `set` at T+1;
  - `play` at T+2 (LOAD);
  - RUN at T+2.
- Never more than one of `set`/`play`/`stop` is high in the same cycle.
- `ring` sampled high in RUN at cycle T gives `alarm_out`=1 at T+1.
- Acknowledge at T gives `alarm_out`=0 and `set`=1 at T+1.
- Timeout: `alarm_out` is high for exactly `RING_TIMEOUT` cycles if no button is pressed.
- `ring` is ignored in IDLE, EDIT, LOAD and PAUSE. The stale high left by the timer before it sees `set` must not re-enter ALARM.
- Asynchronous reset mid-operation:
  - returns to the reset values immediately;
  - any pulse in flight is truncated;
  - no `stop` or `set` is issued on reset exit.

## Test plan
- **Reset/zero guard:** release reset, pulse `btn_start` → no `play`, state stays IDLE, presets 00:00:00.
- **Edit wrap:** mode, down ×1 → hour 8'h23; mode, up ×60 → minute 8'h00; mode, down → second 8'h59; mode → `set` pulse one cycle later, `edit_field` 0.
- **Start from EDIT:** enter EDIT, set second to 8'h05, `btn_start` at T → `set` at T+1, `play` at T+2, each exactly one cycle wide.
- **Pause/resume/abort:** in RUN, start → `stop`; start → `play`; start → `stop`; mode → `set`, state IDLE, preset unchanged.
- **Alarm:** with `RING_TIMEOUT`=100, drive `ring`=1 in RUN → `alarm_out` high for exactly 100 cycles, then `set` pulse. Repeat with `btn_up` at cycle 10 → `alarm_out` low and `set` at cycle 11.
- **Priority/async reset:**
  - `btn_start` and `btn_mode` in the same cycle in IDLE → only `play` issued.
  - Assert `rst_n`=0 during an `alarm_out` high → `alarm_out` drops immediately with no `set` issued.
